// File: rtl/aes_pkg.sv
// Shared AES definitions: mode encodings, key-schedule size lookups,
// GF(2^8) helpers, the S-box function and the InvMixColumns column transform.
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_128 = 2'd0,
        MODE_192 = 2'd1,
        MODE_256 = 2'd2,
        MODE_ILL = 2'd3
    } aes_mode_e;

    // Nk: key length in 32-bit words
    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            MODE_192: nk_of = 4'd6;
            MODE_256: nk_of = 4'd8;
            default:  nk_of = 4'd4;
        endcase
    endfunction

    // Nr: number of rounds
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_192: nr_of = 4'd12;
            MODE_256: nr_of = 4'd14;
            default:  nr_of = 4'd10;
        endcase
    endfunction

    // Total schedule words, 4*(Nr+1)
    function automatic logic [5:0] total_of(input logic [1:0] mode);
        case (mode)
            MODE_192: total_of = 6'd52;
            MODE_256: total_of = 6'd60;
            default:  total_of = 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        gmul = p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'd254;
        for (int k = 0; k < 8; k++) begin
            if (e[k]) r = gmul(r, p);
            p = gmul(p, p);
        end
        sbox = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // InvMixColumns on one column, byte 0 in bits [31:24]
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        inv_mix_col = {
            gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
        };
    endfunction

endpackage

// File: rtl/key_word_sub.sv
// SubWord: applies the S-box to each byte of a 32-bit word.
// RotWord is chosen by the caller before this block.
module key_word_sub (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            S_box u_sbox (
                .din  (din[8*gi +: 8]),
                .dout (dout[8*gi +: 8])
            );
        end
    endgenerate

endmodule

// File: rtl/s_box.sv
// AES forward S-box, single byte, purely combinational.
module S_box
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = sbox(din);

endmodule

// File: rtl/key_expand_seq.sv
// Iterative AES-128/192/256 key expansion, one schedule word per clock,
// with a registered indexed round-key read port.
// Optional feature macro: AES_EQINV_KEY_EN adds rk_inv_data carrying
// InvMixColumns-transformed round keys for the equivalent inverse cipher.
module key_expand_seq
    import aes_pkg::*;
#(
    parameter int MAX_WORDS = 60,
    parameter int IDX_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [255:0]       key,
    output logic               busy,
    output logic               done,
    output logic               key_valid,
    output logic               cfg_err,
    input  logic               rk_rd_en,
    input  logic [IDX_W-1:0]   rk_idx,
    output logic [127:0]       rk_data,
    output logic               rk_rd_vld
`ifdef AES_EQINV_KEY_EN
    ,
    output logic [127:0]       rk_inv_data
`endif
);

    localparam int AW = $clog2(MAX_WORDS);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;

    logic [0:0]    state_reg;
    logic [1:0]    mode_reg;
    logic [AW-1:0] i_reg;
    logic [2:0]    j_reg;
    logic [7:0]    rcon_reg;
    logic [31:0]   bank_reg [MAX_WORDS];

    logic [3:0]    nk;
    logic [3:0]    nr;
    logic [5:0]    total;
    logic [AW-1:0] prev_idx;
    logic [AW-1:0] back_idx;
    logic [31:0]   prev_word;
    logic [31:0]   back_word;
    logic [31:0]   sub_in;
    logic [31:0]   sub_word;
    logic [31:0]   temp_word;
    logic [31:0]   new_word;
    logic          last_word;
    logic [31:0]   key_word [8];

    assign nk    = nk_of(mode_reg);
    assign nr    = nr_of(mode_reg);
    assign total = total_of(mode_reg);
    assign busy  = (state_reg == ST_EXPAND);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_key_word
            assign key_word[gi] = key[255 - 32*gi -: 32];
        end
    endgenerate

    // Indices only matter while expanding; park them at 0 otherwise
    assign prev_idx  = busy ? (i_reg - AW'(1)) : '0;
    assign back_idx  = busy ? (i_reg - AW'(nk)) : '0;
    assign prev_word = bank_reg[prev_idx];
    assign back_word = bank_reg[back_idx];

    // RotWord only on the first word of each Nk group
    assign sub_in = (j_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    key_word_sub u_sub (
        .din  (sub_in),
        .dout (sub_word)
    );

    // Select the transform applied to w[i-1]
    always_comb begin
        temp_word = prev_word;
        if (j_reg == 3'd0) begin
            temp_word = sub_word ^ {rcon_reg, 24'h0};
        end else if (nk == 4'd8 && j_reg == 3'd4) begin
            temp_word = sub_word;
        end
    end

    assign new_word  = back_word ^ temp_word;
    assign last_word = (i_reg == AW'(total - 6'd1));

    // Control FSM, counters and word bank
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            mode_reg  <= MODE_128;
            i_reg     <= '0;
            j_reg     <= '0;
            rcon_reg  <= 8'h01;
            done      <= 1'b0;
            key_valid <= 1'b0;
            cfg_err   <= 1'b0;
            for (int k = 0; k < MAX_WORDS; k++) begin
                bank_reg[k] <= '0;
            end
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (mode == MODE_ILL) begin
                            cfg_err <= 1'b1;
                        end else begin
                            mode_reg  <= mode;
                            key_valid <= 1'b0;
                            i_reg     <= AW'(nk_of(mode));
                            j_reg     <= '0;
                            rcon_reg  <= 8'h01;
                            state_reg <= ST_EXPAND;
                            for (int k = 0; k < 8; k++) begin
                                if (k < int'(nk_of(mode))) begin
                                    bank_reg[k] <= key_word[k];
                                end
                            end
                        end
                    end
                end
                default: begin
                    bank_reg[i_reg] <= new_word;
                    if (j_reg == 3'd0) begin
                        rcon_reg <= xtime(rcon_reg);
                    end
                    if (j_reg == 3'(nk - 4'd1)) begin
                        j_reg <= '0;
                    end else begin
                        j_reg <= j_reg + 3'd1;
                    end
                    if (last_word) begin
                        state_reg <= ST_IDLE;
                        done      <= 1'b1;
                        key_valid <= 1'b1;
                    end else begin
                        i_reg <= i_reg + AW'(1);
                    end
                end
            endcase
        end
    end

    // Read-side address and data gathering
    logic          rd_in_range;
    logic [AW-1:0] rd_base;
    logic [31:0]   rd_word [4];
    logic [127:0]  rd_round;

    assign rd_in_range = ({{(8-IDX_W){1'b0}}, rk_idx} <= {4'd0, nr});
    assign rd_base     = rd_in_range ? AW'({rk_idx, 2'b00}) : '0;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_word
            assign rd_word[gi] = bank_reg[rd_base + AW'(gi)];
        end
    endgenerate

    assign rd_round = {rd_word[0], rd_word[1], rd_word[2], rd_word[3]};

`ifdef AES_EQINV_KEY_EN
    logic [31:0]  inv_col [4];
    logic [127:0] inv_round;
    logic         rd_outer;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_inv_col
            assign inv_col[gi] = inv_mix_col(rd_word[gi]);
        end
    endgenerate

    assign inv_round = {inv_col[0], inv_col[1], inv_col[2], inv_col[3]};
    assign rd_outer  = (rk_idx == '0) || ({{(8-IDX_W){1'b0}}, rk_idx} == {4'd0, nr});
`endif

    // Registered round-key read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_rd_vld <= 1'b0;
            rk_data   <= '0;
`ifdef AES_EQINV_KEY_EN
            rk_inv_data <= '0;
`endif
        end else begin
            rk_rd_vld <= rk_rd_en;
            if (rk_rd_en) begin
                rk_data <= rd_in_range ? rd_round : '0;
`ifdef AES_EQINV_KEY_EN
                rk_inv_data <= !rd_in_range ? '0 : (rd_outer ? rd_round : inv_round);
`endif
            end
        end
    end

endmodule

// File: tb/tb_key_expand_seq.sv
// Self-checking bench for key_expand_seq: FIPS-197 vectors, control corner
// cases, mid-expansion reset; a software key schedule predicts every read.
module tb_key_expand_seq;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] L128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] L192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] L256 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   mode;
    logic [255:0] key;
    logic         busy, done, key_valid, cfg_err;
    logic         rk_rd_en;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         rk_rd_vld;
`ifdef AES_EQINV_KEY_EN
    logic [127:0] rk_inv_data;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    key_expand_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .cfg_err   (cfg_err),
        .rk_rd_en  (rk_rd_en),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .rk_rd_vld (rk_rd_vld)
`ifdef AES_EQINV_KEY_EN
        ,
        .rk_inv_data (rk_inv_data)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- software model ----------------
    logic [7:0]  sb [256];
    logic [31:0] m_w [60];
    int          m_nr = 10;

    // carry-less product then polynomial reduction by x^8+x^4+x^3+x+1
    function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ ({8'h0, a} << i);
        for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
        return acc[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (bmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[a] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] k, input int m);
        int nk;
        logic [31:0] t;
        logic [7:0]  rc;
        nk   = (m == 0) ? 4 : (m == 1) ? 6 : 8;
        m_nr = nk + 6;
        for (int i = 0; i < 60; i++) m_w[i] = '0;
        for (int i = 0; i < nk; i++) m_w[i] = k[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(m_nr+1); i++) begin
            t = m_w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = bmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            m_w[i] = m_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int r);
        if (r > m_nr) return '0;
        return {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
    endfunction

    function automatic logic [31:0] imc(input logic [31:0] c);
        logic [7:0] a [4];
        for (int i = 0; i < 4; i++) a[i] = c[31 - 8*i -: 8];
        return {bmul(a[0],8'd14)^bmul(a[1],8'd11)^bmul(a[2],8'd13)^bmul(a[3],8'd9),
                bmul(a[0],8'd9) ^bmul(a[1],8'd14)^bmul(a[2],8'd11)^bmul(a[3],8'd13),
                bmul(a[0],8'd13)^bmul(a[1],8'd9) ^bmul(a[2],8'd14)^bmul(a[3],8'd11),
                bmul(a[0],8'd11)^bmul(a[1],8'd13)^bmul(a[2],8'd9) ^bmul(a[3],8'd14)};
    endfunction

    function automatic logic [127:0] model_inv(input int r);
        logic [127:0] rk;
        rk = model_rk(r);
        if (r == 0 || r >= m_nr) return rk;
        return {imc(rk[127:96]), imc(rk[95:64]), imc(rk[63:32]), imc(rk[31:0])};
    endfunction

    // ---------------- compare process ----------------
    logic         pend_vld = 1'b0;
    logic         pend_chk = 1'b0;
    logic [127:0] pend_exp = '0;
    logic [127:0] pend_inv = '0;

    always @(posedge clk) begin
        pend_vld <= rst ? 1'b0 : rk_rd_en;
        pend_chk <= !rst && rk_rd_en && key_valid;
        pend_exp <= model_rk(int'(rk_idx));
        pend_inv <= model_inv(int'(rk_idx));
    end

    always @(negedge clk) begin
        check("rd_vld", {127'h0, rk_rd_vld}, {127'h0, pend_vld});
        if (pend_chk) begin
            check("rk_data", rk_data, pend_exp);
`ifdef AES_EQINV_KEY_EN
            check("rk_inv_data", rk_inv_data, pend_inv);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_key(input logic [255:0] k, input logic [1:0] m, input int exp_n, input bit interfere);
        int n;
        bit seen;
        key = k; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_accept", {127'h0, busy}, 128'h1);
        check("kv_after_accept", {127'h0, key_valid}, 128'h0);
        n = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk); n++; #1;
            if (done) seen = 1'b1;
            if (interfere && n == 10) begin
                start = 1'b1; mode = 2'd2; key = K256;
            end
            if (interfere && n == 11) start = 1'b0;
        end
        check("done_latency", 128'(n), 128'(exp_n));
        check("busy_after_done", {127'h0, busy}, 128'h0);
        check("kv_after_done", {127'h0, key_valid}, 128'h1);
        model_expand(k, int'(m));
        @(posedge clk); #1;
        check("done_pulse_end", {127'h0, done}, 128'h0);
    endtask

    task automatic read_rk(input int idx, input logic [127:0] lit, input string name);
        rk_rd_en = 1'b1; rk_idx = 4'(idx);
        @(posedge clk); #1;
        rk_rd_en = 1'b0;
        check(name, rk_data, lit);
    endtask

    task automatic read_all();
        for (int r = 0; r < 16; r++) begin
            rk_rd_en = 1'b1; rk_idx = 4'(r);
            @(posedge clk); #1;
        end
        rk_rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; key = '0; rk_rd_en = 1'b0; rk_idx = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_done", {127'h0, done}, 128'h0);
        check("rst_kv", {127'h0, key_valid}, 128'h0);
        check("rst_cfg_err", {127'h0, cfg_err}, 128'h0);
        check("rst_rk_data", rk_data, 128'h0);

        // pin the model against published vectors
        check("model_sbox53", {120'h0, sb[8'h53]}, 128'hed);
        model_expand(K128, 0); check("model_128", model_rk(10), L128);
        model_expand(K192, 1); check("model_192", model_rk(12), L192);
        model_expand(K256, 2); check("model_256", model_rk(14), L256);
        model_expand(K128, 0);

        run_key(K128, 2'd0, 40, 1'b0);
        read_rk(10, L128, "aes128_r10");
        read_all();
        run_key(K192, 2'd1, 46, 1'b0);
        read_rk(12, L192, "aes192_r12");
        read_all();
        run_key(K256, 2'd2, 52, 1'b0);
        read_rk(14, L256, "aes256_r14");
        read_all();

        // illegal mode while a key is valid
        key = K128; mode = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mode3_cfg_err", {127'h0, cfg_err}, 128'h1);
        check("mode3_busy", {127'h0, busy}, 128'h0);
        check("mode3_kv", {127'h0, key_valid}, 128'h1);
        @(posedge clk); #1;
        check("mode3_cfg_err_pulse", {127'h0, cfg_err}, 128'h0);
        read_rk(14, L256, "mode3_key_kept");

        // start pulsed during expansion is ignored
        run_key(K128, 2'd0, 40, 1'b1);
        read_rk(10, L128, "midstart_r10");
        read_rk(11, 128'h0, "aes128_r11_zero");
        read_all();

        // reset in the middle of an expansion
        key = K128; mode = 2'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {127'h0, busy}, 128'h0);
        check("abort_kv", {127'h0, key_valid}, 128'h0);
        check("abort_rk_data", rk_data, 128'h0);
        read_rk(1, 128'h0, "abort_bank_cleared");

        run_key(K128, 2'd0, 40, 1'b0);
        read_rk(10, L128, "restart_r10");
        read_all();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
